// File: rtl/dct_block_scheduler_if.sv
// dct_block_scheduler_if: DCT core and downstream coefficient handshake bundle
// core_start/core_ready/core_coef face the DCT core; out_valid/out_data/out_index/out_ack face the quantizer.
// master: the scheduler side; slave: the core/downstream side.
interface dct_block_scheduler_if #(
    parameter int COEF_W = 16
);
    logic              core_start;
    logic              core_ready;
    logic [COEF_W-1:0] core_coef;
    logic              out_valid;
    logic [COEF_W-1:0] out_data;
    logic [5:0]        out_index;
    logic              out_ack;
    modport master (
        output core_start, out_valid, out_data, out_index,
        input  core_ready, core_coef, out_ack
    );
    modport slave (
        input  core_start, out_valid, out_data, out_index,
        output core_ready, core_coef, out_ack
    );
endinterface

// File: rtl/dct_block_scheduler.sv
// dct_block_scheduler: raster-order frame walker for the 8x8 DCT core with a coefficient FIFO
// clk, rst_in (sync, active-low), frame_start (request, honoured in IDLE only)
// bus (master): core_start pulse, core_ready/core_coef capture, out_valid/out_data/out_index/out_ack drain
// blk_x/blk_y current block, busy outside IDLE, frame_done one-cycle pulse, err sticky overflow/stray flag
module dct_block_scheduler #(
    parameter int FRAME_W_BLK = 4,
    parameter int FRAME_H_BLK = 3,
    parameter int COEF_W = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int XW = FRAME_W_BLK > 1 ? $clog2(FRAME_W_BLK) : 1,
    localparam int YW = FRAME_H_BLK > 1 ? $clog2(FRAME_H_BLK) : 1
) (
    input  logic          clk,
    input  logic          rst_in,
    input  logic          frame_start,
    dct_block_scheduler_if.master bus,
    output logic [XW-1:0] blk_x,
    output logic [YW-1:0] blk_y,
    output logic          busy,
    output logic          frame_done,
    output logic          err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [2:0] {IDLE, START_BLK, COLLECT, DRAIN, NEXT_BLK, DONE} state_t;
    state_t state, state_nxt;
    logic [COEF_W+5:0] mem [FIFO_DEPTH];
    logic [COEF_W+5:0] head;
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [5:0] coef_cnt;
    logic full, pop, push, drop, stray, accept, last_x, last_y;
    always_comb begin
        full = cnt == CW'(FIFO_DEPTH);
        pop = cnt != '0 && bus.out_ack;
        // a full FIFO still takes a push when the head leaves in the same cycle
        push = state == COLLECT && bus.core_ready && (!full || pop);
        drop = state == COLLECT && bus.core_ready && full && !pop;
        stray = bus.core_ready && state != COLLECT;
        accept = state == IDLE && frame_start;
        last_x = blk_x == XW'(FRAME_W_BLK - 1);
        last_y = blk_y == YW'(FRAME_H_BLK - 1);
        cnt_nxt = cnt + CW'(push) - CW'(pop);
        head = mem[rp];
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = frame_start ? START_BLK : IDLE;
            START_BLK: state_nxt = COLLECT;
            // dropped strobes still count, so the block always ends on the 64th strobe
            COLLECT:   state_nxt = bus.core_ready && coef_cnt == 6'd63 ? DRAIN : COLLECT;
            DRAIN:     state_nxt = cnt_nxt == '0 ? NEXT_BLK : DRAIN;
            NEXT_BLK:  state_nxt = last_x && last_y ? DONE : START_BLK;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end
    always_comb begin
        bus.core_start = state == START_BLK;
        bus.out_valid = cnt != '0;
        bus.out_data = cnt != '0 ? head[COEF_W-1:0] : '0;
        bus.out_index = cnt != '0 ? head[COEF_W+5:COEF_W] : '0;
        busy = state != IDLE;
        frame_done = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= {coef_cnt, bus.core_coef};
    end
    always_ff @(posedge clk) begin
        if (!rst_in) begin
            state <= IDLE;
            cnt <= '0;
            wp <= '0;
            rp <= '0;
            coef_cnt <= '0;
            blk_x <= '0;
            blk_y <= '0;
            err <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            if (state == START_BLK) coef_cnt <= '0;
            else if (state == COLLECT && bus.core_ready) coef_cnt <= coef_cnt + 1'b1;
            if (accept) begin
                blk_x <= '0;
                blk_y <= '0;
            end else if (state == NEXT_BLK && !(last_x && last_y)) begin
                blk_x <= last_x ? '0 : blk_x + 1'b1;
                blk_y <= last_x ? blk_y + 1'b1 : blk_y;
            end
            err <= stray || drop ? 1'b1 : accept ? 1'b0 : err;
        end
    end
endmodule

// File: tb/tb_dct_block_scheduler.sv
// tb_dct_block_scheduler: table, directed and random checks of dct_block_scheduler against a queue model
module tb_dct_block_scheduler;
    localparam int W = 4;
    localparam int H = 3;
    localparam int D = 4;
    logic clk = 1'b0;
    logic rst_in, frame_start, frame_start1;
    logic [1:0] blk_x, blk_y;
    logic blk_x1, blk_y1;
    logic busy, frame_done, err, busy1, frame_done1, err1;
    dct_block_scheduler_if #(.COEF_W(16)) bus();
    dct_block_scheduler_if #(.COEF_W(16)) bus1();
    dct_block_scheduler #(.FRAME_W_BLK(W), .FRAME_H_BLK(H), .COEF_W(16), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_in(rst_in), .frame_start(frame_start), .bus(bus),
        .blk_x(blk_x), .blk_y(blk_y), .busy(busy), .frame_done(frame_done), .err(err)
    );
    dct_block_scheduler #(.FRAME_W_BLK(1), .FRAME_H_BLK(1), .COEF_W(16), .FIFO_DEPTH(D)) dut1 (
        .clk(clk), .rst_in(rst_in), .frame_start(frame_start1), .bus(bus1),
        .blk_x(blk_x1), .blk_y(blk_y1), .busy(busy1), .frame_done(frame_done1), .err(err1)
    );
    always #5 clk = ~clk;

    typedef struct {
        bit rst, fs, rdy, ack;
        logic [15:0] coef;
        bit e_start, e_busy, e_valid, e_err;
        logic [5:0] e_idx;
        logic [15:0] e_data;
    } vec_t;
    vec_t tv[9];

    int total = 0, bad = 0;
    bit d_rst, d_fs, d_rdy, d_ack, e_fs, e_rdy, e_ack;
    logic [15:0] d_coef, e_coef;
    // reference model: FIFO contents as a queue, frame progress as event times
    logic [21:0] q[$];
    bit err_m, fr_on, in_blk;
    int cyc = 0, start_at = -1, done_at = -1, sent = 0, blk_n = 0, bx_m = 0, by_m = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit can_strobe();
        return in_blk && cyc > start_at && sent < 64;
    endfunction

    task automatic idle_in();
        d_rst = 1; d_fs = 0; d_rdy = 0; d_ack = 0; d_coef = '0;
        e_fs = 0; e_rdy = 0; e_ack = 0; e_coef = '0;
    endtask

    task automatic check();
        if (cyc == start_at) begin
            bx_m = blk_n % W;
            by_m = blk_n / W;
        end
        chk("core_start", 32'(bus.core_start), 32'(cyc == start_at));
        chk("frame_done", 32'(frame_done), 32'(cyc == done_at));
        chk("busy", 32'(busy), 32'(fr_on));
        chk("blk_x", 32'(blk_x), bx_m);
        chk("blk_y", 32'(blk_y), by_m);
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        chk("out_head", 32'({bus.out_index, bus.out_data}), q.size() != 0 ? 32'(q[0]) : 32'd0);
        chk("err", 32'(err), 32'(err_m));
    endtask

    task automatic tick();
        bit pop, coll;
        rst_in = d_rst; frame_start = d_fs;
        bus.core_ready = d_rdy; bus.core_coef = d_coef; bus.out_ack = d_ack;
        frame_start1 = e_fs;
        bus1.core_ready = e_rdy; bus1.core_coef = e_coef; bus1.out_ack = e_ack;
        if (!d_rst) begin
            q.delete();
            err_m = 0; fr_on = 0; in_blk = 0;
            start_at = -1; done_at = -1; sent = 0; blk_n = 0; bx_m = 0; by_m = 0;
        end else begin
            pop = q.size() != 0 && d_ack;
            coll = can_strobe();
            if (d_fs && !fr_on) begin
                fr_on = 1; err_m = 0; in_blk = 1; start_at = cyc + 1;
                blk_n = 0; sent = 0; bx_m = 0; by_m = 0;
            end
            if (pop) void'(q.pop_front());
            if (d_rdy) begin
                if (!coll) err_m = 1;
                else begin
                    if (q.size() < D) q.push_back({6'(sent), d_coef});
                    else err_m = 1;
                    sent++;
                end
            end
            if (in_blk && sent == 64 && pop && q.size() == 0) begin
                if (blk_n == W * H - 1) begin
                    in_blk = 0;
                    done_at = cyc + 2;
                end else begin
                    blk_n++;
                    start_at = cyc + 2;
                    sent = 0;
                end
            end
            if (cyc == done_at) fr_on = 0;
        end
        @(negedge clk);
        cyc++;
        check();
    endtask

    task automatic drive_rand();
        idle_in();
        d_rdy = can_strobe() && $urandom_range(0, 2) == 0;
        d_ack = $urandom_range(0, 3) != 0;
        d_coef = 16'($urandom);
        d_fs = fr_on && $urandom_range(0, 63) == 0;
    endtask

    task automatic rand_until_start();
        int i;
        for (i = 0; i < 5000; i++) begin
            drive_rand();
            tick();
            if (bus.core_start) break;
        end
        chk("start_wait", 32'(bus.core_start), 32'd1);
    endtask

    task automatic rand_until_idle();
        for (int i = 0; i < 20000 && fr_on; i++) begin
            drive_rand();
            tick();
        end
        chk("frame_end", 32'(busy), 32'd0);
    endtask

    initial begin
        int starts, xfers, dones, n1, starts1, xfers1, last_pop, done_c;
        tv[0] = '{0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 6'd0, 16'h0000};
        tv[1] = '{1, 0, 1, 0, 16'h0abc, 0, 0, 0, 1, 6'd0, 16'h0000};
        tv[2] = '{1, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 6'd0, 16'h0000};
        tv[3] = '{1, 1, 0, 0, 16'h0000, 1, 1, 0, 0, 6'd0, 16'h0000};
        tv[4] = '{1, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 6'd0, 16'h0000};
        tv[5] = '{1, 0, 1, 0, 16'h1111, 0, 1, 1, 0, 6'd0, 16'h1111};
        tv[6] = '{1, 0, 1, 1, 16'h2222, 0, 1, 1, 0, 6'd1, 16'h2222};
        tv[7] = '{1, 0, 0, 1, 16'h0000, 0, 1, 0, 0, 6'd0, 16'h0000};
        tv[8] = '{1, 0, 0, 1, 16'h0000, 0, 1, 0, 0, 6'd0, 16'h0000};
        idle_in();
        for (int i = 0; i < 9; i++) begin
            idle_in();
            d_rst = tv[i].rst; d_fs = tv[i].fs; d_rdy = tv[i].rdy; d_ack = tv[i].ack; d_coef = tv[i].coef;
            tick();
            chk("tv_start", 32'(bus.core_start), 32'(tv[i].e_start));
            chk("tv_busy", 32'(busy), 32'(tv[i].e_busy));
            chk("tv_valid", 32'(bus.out_valid), 32'(tv[i].e_valid));
            chk("tv_err", 32'(err), 32'(tv[i].e_err));
            chk("tv_idx", 32'(bus.out_index), 32'(tv[i].e_idx));
            chk("tv_data", 32'(bus.out_data), 32'(tv[i].e_data));
        end
        // fresh frame: full FIFO with simultaneous push and pop loses nothing
        idle_in(); d_rst = 0; tick();
        idle_in(); d_fs = 1; tick();
        chk("f0_start", 32'(bus.core_start), 32'd1);
        idle_in(); tick();
        for (int i = 0; i < 4; i++) begin
            idle_in(); d_rdy = 1; d_coef = 16'(16'h100 + i); tick();
        end
        chk("full_err", 32'(err), 32'd0);
        idle_in(); d_rdy = 1; d_ack = 1; d_coef = 16'h104; tick();
        chk("simul_err", 32'(err), 32'd0);
        chk("simul_head", 32'(bus.out_index), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("simul_drain", 32'({bus.out_index, bus.out_data}), 32'({6'(i), 16'(16'h100 + i)}));
            idle_in(); d_ack = 1; tick();
        end
        chk("simul_empty", 32'(bus.out_valid), 32'd0);
        // second block: ack held low while strobes arrive every cycle
        rand_until_start();
        idle_in(); tick();
        for (int i = 0; i < 10; i++) begin
            idle_in(); d_rdy = 1; d_coef = 16'($urandom); tick();
        end
        chk("ovf_err", 32'(err), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_idx", 32'(bus.out_index), i);
            idle_in(); d_ack = 1; tick();
        end
        chk("ovf_empty", 32'(bus.out_valid), 32'd0);
        rand_until_idle();
        // random frame interrupted by reset during block (2,1)
        idle_in(); d_fs = 1; tick();
        for (int i = 0; i < 20000 && !(in_blk && blk_n == 6 && sent >= 5); i++) begin
            drive_rand();
            tick();
        end
        chk("reach_blk", 32'({blk_x, blk_y}), 32'({2'd2, 2'd1}));
        idle_in(); d_rst = 0; d_rdy = 1; d_ack = 1; tick();
        chk("rst_outs", 32'({bus.core_start, bus.out_valid, busy, frame_done, err, blk_x, blk_y}), 32'd0);
        chk("rst_head", 32'({bus.out_index, bus.out_data}), 32'd0);
        idle_in(); d_fs = 1; tick();
        starts = bus.core_start ? 1 : 0;
        chk("restart_blk", 32'({blk_x, blk_y}), 32'd0);
        xfers = 0; dones = 0;
        for (int i = 0; i < 6000; i++) begin
            idle_in(); d_ack = 1; d_rdy = can_strobe() && cyc % 3 == 0; d_coef = 16'($urandom);
            if (bus.out_valid) begin
                chk("seq_idx", 32'(bus.out_index), xfers % 64);
                xfers++;
            end
            tick();
            if (bus.core_start) starts++;
            if (frame_done) dones++;
            if (dones != 0 && !busy) break;
        end
        chk("seq_starts", starts, 12);
        chk("seq_xfers", xfers, 768);
        chk("seq_dones", dones, 1);
        chk("seq_err", 32'(err), 32'd0);
        // single-block frame on the 1x1 instance
        idle_in(); e_fs = 1; tick();
        chk("one_start", 32'(bus1.core_start), 32'd1);
        chk("one_busy", 32'(busy1), 32'd1);
        n1 = 0; starts1 = 1; xfers1 = 0; last_pop = -100; done_c = -1;
        for (int i = 0; i < 400 && !(done_c >= 0 && cyc > done_c + 1); i++) begin
            idle_in();
            e_ack = 1; e_rdy = i > 0 && n1 < 64; e_coef = 16'(n1 * 3 + 1); e_fs = i == 5;
            if (e_rdy) n1++;
            if (bus1.out_valid) begin
                chk("one_idx", 32'(bus1.out_index), xfers1 % 64);
                chk("one_data", 32'(bus1.out_data), 32'(16'(xfers1 * 3 + 1)));
                xfers1++;
                last_pop = cyc;
            end
            tick();
            if (bus1.core_start) starts1++;
            if (frame_done1) done_c = cyc;
            if (done_c >= 0 && cyc == done_c + 1) chk("one_idle", 32'(busy1), 32'd0);
        end
        chk("one_xfers", xfers1, 64);
        chk("one_starts", starts1, 1);
        chk("one_done_gap", done_c - last_pop, 2);
        chk("one_err", 32'(err1), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dct_block_scheduler.md
# dct_block_scheduler

Frame-level scheduler for the 8x8 DCT core. It walks a frame of FRAME_W_BLK x FRAME_H_BLK blocks in raster order and pulses the core's start once per block. It captures the 64 coefficients the core emits via its ready strobe into a small FIFO, and forwards them downstream over a valid/ack handshake. It sits between the frame controller and the DCT core on one side, and the quantizer/entropy stage on the other.

## Interface
- FRAME_W_BLK, 4, blocks per row (≥1)
- FRAME_H_BLK, 3, block rows per frame (≥1)
- COEF_W, 16, coefficient width
- FIFO_DEPTH, 4, coefficient FIFO entries (power of two, ≥2)
- clk  in  1  single clock; all registers update on rising edge
- rst_in  in  1  reset, synchronous, active-low
- frame_start  in  1  one-cycle request to process a frame; honoured only in IDLE
- core_start  out  1  one-cycle start pulse to the DCT core
- core_ready  in  1  one-cycle strobe: core_coef valid this cycle
- core_coef  in  COEF_W  coefficient from core
- blk_x  out  $clog2(FRAME_W_BLK) (min 1)  current block column
- blk_y  out  $clog2(FRAME_H_BLK) (min 1)  current block row
- out_valid  out  1  FIFO head valid
- out_data  out  COEF_W  FIFO head coefficient
- out_index  out  6  coefficient index 0..63 within block, in core emission order
- out_ack  in  1  downstream accepts head when out_valid=1
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse when the last block has drained
- err  out  1  sticky: overflow or stray core_ready

## Operation
- States: IDLE, START_BLK, COLLECT, DRAIN, NEXT_BLK, DONE.
- IDLE: frame_start=1 → clear blk_x/blk_y, clear err, go START_BLK.
- START_BLK: core_start=1 for exactly this cycle; clear coef_cnt; go COLLECT.
- COLLECT: each core_ready pushes {coef_cnt, core_coef} and increments coef_cnt.
  - The push with coef_cnt==63 moves to DRAIN.
- DRAIN: stay until the FIFO is empty, then go NEXT_BLK.
- NEXT_BLK:
  - If blk_x==FRAME_W_BLK-1 and blk_y==FRAME_H_BLK-1 → DONE.
  - Else if blk_x==FRAME_W_BLK-1 → blk_x=0, blk_y+1, go START_BLK.
  - Else → blk_x+1, go START_BLK.
- DONE: frame_done=1 for this cycle; go IDLE. blk_x/blk_y hold their last values until the next accepted frame_start.
- FIFO:
  - Pop when out_valid && out_ack.
  - Push while full with a simultaneous pop: legal, no loss.
  - Push while full without a pop: coefficient dropped, coef_cnt still increments, err=1.
- core_ready in any state other than COLLECT: ignored (no push), err=1.
- frame_start outside IDLE: ignored, err unchanged.
- err clears only on reset or an accepted frame_start.
- out_index is a 6-bit value; coef_cnt wraps naturally after 63, but the state exits COLLECT at that point.

## Timing
- Reset (rst_in=0 at a rising edge) → state IDLE, FIFO empty, coef_cnt=0, blk_x=blk_y=0.
  - All outputs 0: core_start, out_valid, out_data, out_index, busy, frame_done, err.
  - Reset mid-frame aborts immediately; the FIFO contents are discarded.
- frame_start at cycle N (IDLE) → core_start=1 and busy=1 at N+1.
- core_ready at cycle M into an empty FIFO → out_valid=1 at M+1 with that data/index.
- out_valid && out_ack at cycle K → the next entry (if any) is presented at K+1; otherwise out_valid=0 at K+1.
- out_ack held high on an empty FIFO has no effect.
- 64th core_ready at cycle M → DRAIN at M+1.
- If the FIFO empties at cycle E:
  - NEXT_BLK at E+1.
  - core_start for the next block at E+2.
  - For the last block, frame_done at E+2 and IDLE/busy=0 at E+3.
- Minimum block-to-block gap from the final pop to the next core_start: 2 cycles.

## Test plan
- Default params, ack tied high, core_ready every 3 cycles → 12 core_start pulses; 768 out transfers with index 0..63 repeating; blk sequence (0,0),(1,0)..(3,2); one frame_done; err=0.
- out_ack low for 10 cycles while core_ready fires every cycle, FIFO_DEPTH=4 → exactly 4 coefficients retained, err=1, out_index of the retained entries 0..3, block still completes after 64 strobes.
- FIFO full, with core_ready and out_ack in the same cycle → no drop, err stays 0, FIFO occupancy unchanged.
- core_ready pulsed in IDLE, then frame_start → err=1 after the stray pulse, cleared to 0 the cycle after frame_start is accepted.
- rst_in=0 for one cycle during COLLECT of block (2,1) → next cycle IDLE, all outputs 0; a new frame_start restarts at block (0,0) with index 0.
- FRAME_W_BLK=1, FRAME_H_BLK=1 → a single core_start, 64 transfers, frame_done 2 cycles after the last pop, frame_start during busy ignored.
